// File: rtl/uart_tx_fifo_mm.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_mm
//   Memory-mapped UART transmitter for the IO page. CPU writes to DATA are
//   queued in a TX FIFO and a serialiser drains them back-to-back using a
//   runtime-programmable baud divisor. STATUS exposes empty/overflow/busy/full
//   and the FIFO fill level, CTRL provides enable, flush and a done interrupt.
//
//   Optional build macro: UART_TX_PARITY_EN
//     When defined, CTRL[4] parity_en and CTRL[2] parity_odd are implemented
//     and a parity bit is inserted between the data bits and the stop bit(s).
//     When undefined, those CTRL bits read 0 and writes to them are ignored.
//
// Ports
//   i_clk    system clock
//   i_rst    asynchronous active-high reset
//   i_sel    block select from IO page decode
//   i_we     write strobe, qualified by i_sel
//   i_addr   word index: 0 DATA, 1 STATUS, 2 DIV, 3 CTRL
//   i_wdata  write data
//   o_rdata  read data, combinational from i_addr, no read side effects
//   o_tx     serial output, idle high, driven from a flop
//   o_irq    level interrupt: irq_en & FIFO empty & serialiser idle (registered)
//
// Register map
//   DATA   (0) W: push i_wdata[7:0] if not full. R: 0
//   STATUS (1) R: [0] empty [1] overflow [8] busy [9] full [23:16] count
//              W: bit1=1 clears overflow
//   DIV    (2) RW [15:0] bit period in clocks (0 behaves as 1)
//   CTRL   (3) [0] enable [1] flush (write-only) [2] parity_odd [3] irq_en
//              [4] parity_en
// -----------------------------------------------------------------------------
module uart_tx_fifo_mm #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 8,
  parameter int STOP_BITS   = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   DIV_RST   = 16'(CLK_FREQ_HZ / BAUD_RATE);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif

  // FIFO storage and pointers
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  // Programmable registers
  logic [15:0]   div_q, div_d;
  logic          en_q, en_d;
  logic          irq_en_q, irq_en_d;
`ifdef UART_TX_PARITY_EN
  logic          par_en_q, par_en_d;
  logic          par_odd_q, par_odd_d;
  logic          fpar_en_q, fpar_en_d;
  logic          fpar_odd_q, fpar_odd_d;
`endif

  // Serialiser
  logic [2:0]    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [15:0]   baud_q, baud_d;
  logic [15:0]   fdiv_q, fdiv_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;

  // Bus decode and FIFO flags
  logic          wr_en;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          flush;
  logic          frame_start;
  logic          empty;
  logic          full;
  logic          busy;
  logic          baud_done;
  logic [15:0]   div_eff;

  // Upper write-data bits have no register behind them.
  logic          unused_wdata;
  assign unused_wdata = ^i_wdata[31:16];

  assign wr_en     = i_sel & i_we;
  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign busy      = (state_q != ST_IDLE);
  assign push_req  = wr_en && (i_addr == ADDR_DATA);
  // Full is judged on the pre-edge count: a same-cycle pop does not make room.
  assign push      = push_req && !full;
  assign flush     = wr_en && (i_addr == ADDR_CTRL) && i_wdata[1];
  assign baud_done = (baud_q == 16'd0);
  assign div_eff   = (div_q == 16'd0) ? 16'd1 : div_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    baud_d      = baud_q;
    fdiv_d      = fdiv_q;
    tx_d        = tx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    div_d       = div_q;
    en_d        = en_q;
    irq_en_d    = irq_en_q;
    pop         = 1'b0;
    frame_start = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    fpar_en_d   = fpar_en_q;
    fpar_odd_d  = fpar_odd_q;
`endif

    // Serialiser sequencing; every bit period is fdiv_q clocks, counted down
    // from fdiv_q-1 to 0.
    case (state_q)
      ST_IDLE: begin
        if (en_q && !empty) begin
          frame_start = 1'b1;
        end
      end
      ST_START: begin
        if (baud_done) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          baud_d  = fdiv_q - 16'd1;
        end else begin
          baud_d  = baud_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = fdiv_q - 16'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            if (fpar_en_q) begin
              state_d = ST_PARITY;
              tx_d    = (^shift_q) ^ fpar_odd_q;
            end else begin
              state_d = ST_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
`else
            state_d = ST_STOP;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[bit_d];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_done) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
          baud_d  = fdiv_q - 16'd1;
        end else begin
          baud_d  = baud_q - 16'd1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_done) begin
          if (stop_q == STOP_LAST) begin
            // End of frame: chain straight into the next start bit if possible.
            if (en_q && !empty) begin
              frame_start = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = 1'b1;
            baud_d = fdiv_q - 16'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start: pop the head, freeze divisor (and parity config) for the frame.
    if (frame_start) begin
      pop      = 1'b1;
      state_d  = ST_START;
      tx_d     = 1'b0;
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
      fdiv_d   = div_eff;
      baud_d   = div_eff - 16'd1;
`ifdef UART_TX_PARITY_EN
      fpar_en_d  = par_en_q;
      fpar_odd_d = par_odd_q;
`endif
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    // Flush discards everything still queued; a byte popped on this edge is
    // already in the shift register and still goes out.
    if (flush) begin
      rd_ptr_d = wr_ptr_d;
      count_d  = '0;
    end

    if (push_req && full) begin
      ovf_d = 1'b1;
    end

    if (wr_en) begin
      case (i_addr)
        ADDR_STATUS: if (i_wdata[1]) ovf_d = 1'b0;
        ADDR_DIV:    div_d = i_wdata[15:0];
        ADDR_CTRL: begin
          en_d     = i_wdata[0];
          irq_en_d = i_wdata[3];
`ifdef UART_TX_PARITY_EN
          par_odd_d = i_wdata[2];
          par_en_d  = i_wdata[4];
`endif
        end
        default: ;
      endcase
    end

    irq_d = irq_en_q && empty && (state_q == ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Control state (asynchronous reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      bit_q    <= 3'd0;
      stop_q   <= 1'b0;
      baud_q   <= 16'd0;
      fdiv_q   <= 16'd1;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DIV_RST;
      en_q     <= 1'b1;
      irq_en_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      fpar_en_q  <= 1'b0;
      fpar_odd_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      baud_q   <= baud_d;
      fdiv_q   <= fdiv_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      fpar_en_q  <= fpar_en_d;
      fpar_odd_q <= fpar_odd_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Data storage (no reset; contents are only observed after a pop)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_wdata[7:0];
    end
    shift_q <= shift_d;
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    o_rdata = '0;
    case (i_addr)
      ADDR_STATUS: begin
        o_rdata[0]     = empty;
        o_rdata[1]     = ovf_q;
        o_rdata[8]     = busy;
        o_rdata[9]     = full;
        o_rdata[23:16] = 8'(count_q);
      end
      ADDR_DIV: o_rdata[15:0] = div_q;
      ADDR_CTRL: begin
        o_rdata[0] = en_q;
        o_rdata[3] = irq_en_q;
`ifdef UART_TX_PARITY_EN
        o_rdata[2] = par_odd_q;
        o_rdata[4] = par_en_q;
`endif
      end
      default: ;
    endcase
  end

  assign o_tx  = tx_q;
  assign o_irq = irq_q;

endmodule
